// File: rtl/pattern_resp_pkg.sv
// Shared types and MISR reference for the pattern response capture stage.
// Default-width misr() lets benches recompute signatures directly.
package pattern_resp_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam int          DEF_SIG_W = 16;
  localparam logic [15:0] DEF_POLY  = 16'h1021;
  localparam logic [15:0] DEF_SEED  = 16'h0000;

  function automatic logic [15:0] misr(
    input logic [15:0] s,
    input logic [15:0] r
  );
    return {s[14:0], 1'b0}
         ^ (s[15] ? DEF_POLY : 16'h0000)
         ^ r;
  endfunction

endpackage

// File: rtl/pattern_resp_misr_core.sv
// Multiple-input signature register: shift, polynomial feedback, XOR-in.
// Seed load wins over update; async active-low reset also loads the seed.
module misr_core #(
  parameter int          RESP_W = 9,
  parameter int          SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY = 16'h1021,
  parameter logic [SIG_W-1:0] SEED = 16'h0000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              en_i,
  input  logic [RESP_W-1:0] resp_i,
  output logic [SIG_W-1:0]  sig_o
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  // Next signature: shift left, fold MSB through POLY, absorb response.
  always_comb begin
    sig_d = {sig_q[SIG_W-2:0], 1'b0}
          ^ (sig_q[SIG_W-1] ? POLY : '0)
          ^ SIG_W'(resp_i);
  end

  // Signature register with seed load and update enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sig_q <= SEED;
    end else if (load_i) begin
      sig_q <= SEED;
    end else if (en_i) begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/pattern_resp_misr.sv
// Response capture: input stage, settle window, MISR compaction, done flag.
// FSM, counters and input register live here; MISR math is in misr_core.
module pattern_resp_misr
  import pattern_resp_pkg::*;
#(
  parameter int               RESP_W = 9,
  parameter int               SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = 16'h1021,
  parameter logic [SIG_W-1:0] SEED   = 16'h0000,
  parameter int               CNT_W  = 16,
  parameter int               SETTLE = 2
) (
  input  logic              blif_clk_net_1_r_2,
  input  logic              blif_reset_net_1_r_2,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  num_cycles_i,
  input  logic [RESP_W-1:0] resp_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [SIG_W-1:0]  signature_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int SET_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int SET_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;

  logic              clk;
  logic              rst_n;
  state_e            state_q;
  logic [RESP_W-1:0] resp_q;
  logic [SET_W-1:0]  settle_q;
  logic [CNT_W-1:0]  n_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;
  logic              load;
  logic              upd;

  assign clk   = blif_clk_net_1_r_2;
  assign rst_n = blif_reset_net_1_r_2;

  assign load = start_i
             && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign upd  = (state_q == S_RUN) && (n_q != '0);

  // One-cycle input stage; the MISR only ever sees resp_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q <= '0;
    end else begin
      resp_q <= resp_i;
    end
  end

  // Run control: settle window, update counting, terminal detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      n_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q  <= (SETTLE == 0) ? S_RUN : S_SETTLE;
            settle_q <= '0;
            n_q      <= num_cycles_i;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
          end
        end
        S_SETTLE: begin
          settle_q <= settle_q + 1'b1;
          if (settle_q == SET_W'(SET_LAST)) begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (n_q == '0) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q + 1'b1 == n_q) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  misr_core #(
    .RESP_W (RESP_W),
    .SIG_W  (SIG_W),
    .POLY   (POLY),
    .SEED   (SEED)
  ) u_misr (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .load_i (load),
    .en_i   (upd),
    .resp_i (resp_q),
    .sig_o  (signature_o)
  );

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign count_o = cnt_q;

endmodule

// File: tb/tb_pattern_resp_misr.sv
// Bench for pattern_resp_misr: table vectors, random runs, reset cases.
// Three instances differ only in SEED (0x0000, 0x0001, 0x8000).
module tb_pattern_resp_misr;

  localparam int ST = 2;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] num;
  logic [8:0]  resp;

  logic        busy [3];
  logic        done [3];
  logic [15:0] sig  [3];
  logic [15:0] cnt  [3];

  logic [15:0] seeds [3];

  logic [8:0]  rbuf [0:299];

  int nvec;
  int nerr;

  pattern_resp_misr #(.SEED(16'h0000)) dut0 (
    .blif_clk_net_1_r_2   (clk),
    .blif_reset_net_1_r_2 (rst_n),
    .start_i              (start),
    .num_cycles_i         (num),
    .resp_i               (resp),
    .busy_o               (busy[0]),
    .done_o               (done[0]),
    .signature_o          (sig[0]),
    .count_o              (cnt[0])
  );

  pattern_resp_misr #(.SEED(16'h0001)) dut1 (
    .blif_clk_net_1_r_2   (clk),
    .blif_reset_net_1_r_2 (rst_n),
    .start_i              (start),
    .num_cycles_i         (num),
    .resp_i               (resp),
    .busy_o               (busy[1]),
    .done_o               (done[1]),
    .signature_o          (sig[1]),
    .count_o              (cnt[1])
  );

  pattern_resp_misr #(.SEED(16'h8000)) dut8 (
    .blif_clk_net_1_r_2   (clk),
    .blif_reset_net_1_r_2 (rst_n),
    .start_i              (start),
    .num_cycles_i         (num),
    .resp_i               (resp),
    .busy_o               (busy[2]),
    .done_o               (done[2]),
    .signature_o          (sig[2]),
    .count_o              (cnt[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Polynomial-division view of the MISR over the sampled window.
  function automatic logic [15:0] model(input logic [15:0] seed,
                                        input int n);
    int s;
    s = int'(seed);
    for (int i = 0; i < n; i++) begin
      s = s * 2;
      if (s >= 65536) s = (s - 65536) ^ 32'h1021;
      s = s ^ int'(rbuf[ST + i]);
    end
    return s[15:0];
  endfunction

  function automatic logic [15:0] pkg_model(input logic [15:0] seed,
                                            input int n);
    logic [15:0] s;
    s = seed;
    for (int i = 0; i < n; i++)
      s = pattern_resp_pkg::misr(s, {7'd0, rbuf[ST + i]});
    return s;
  endfunction

  // One run on all instances; latency/done checks on instance sel.
  task automatic do_run(input int sel, input int n, input bit rnd,
                        input logic [8:0] cval, input bit mid,
                        output logic [15:0] s_o,
                        output logic [15:0] c_o);
    bit   was_done;
    int   e;
    int   lim;
    int   exp_lat;
    logic [15:0] hold;
    for (int k = 0; k < 300; k++)
      rbuf[k] = rnd ? 9'($urandom) : cval;
    was_done = done[sel];
    exp_lat  = (n == 0) ? ST + 1 : ST + n;
    lim      = exp_lat + 20;
    start = 1'b1;
    num   = 16'(n);
    resp  = rbuf[0];
    @(posedge clk); #1;
    if (was_done) chk("done_drop", {31'd0, done[sel]}, 32'd0);
    chk("busy_on_start", {31'd0, busy[sel]}, 32'd1);
    e = 0;
    while (!done[sel] && e < lim) begin
      start = (mid && e == ST) ? 1'b1 : 1'b0;
      if (mid && e == ST) num = 16'hFFFF;
      resp = rbuf[e + 1];
      @(posedge clk); #1;
      e++;
    end
    start = 1'b0;
    chk("latency", 32'(e), 32'(exp_lat));
    chk("busy_at_done", {31'd0, busy[sel]}, 32'd0);
    s_o  = sig[sel];
    c_o  = cnt[sel];
    hold = sig[sel];
    resp = 9'($urandom);
    @(posedge clk); #1;
    chk("done_hold", {16'd0, sig[sel]}, {16'd0, hold});
  endtask

  typedef struct {
    string       nm;
    int          sel;
    int          n;
    logic [8:0]  cval;
    logic [15:0] exp_sig;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl [4];

  initial begin
    logic [15:0] s;
    logic [15:0] c;
    int          n;
    nvec = 0;
    nerr = 0;
    seeds[0] = 16'h0000;
    seeds[1] = 16'h0001;
    seeds[2] = 16'h8000;

    tbl[0] = '{"zero_shift", 1, 4, 9'h000, 16'h0010, 16'd4};
    tbl[1] = '{"const_resp", 0, 2, 9'h001, 16'h0003, 16'd2};
    tbl[2] = '{"feedback",   2, 1, 9'h000, 16'h1021, 16'd1};
    tbl[3] = '{"n_zero",     0, 0, 9'h1FF, 16'h0000, 16'd0};

    rst_n = 1'b0;
    start = 1'b0;
    num   = 16'd0;
    resp  = 9'd0;
    for (int i = 0; i < 5; i++) begin
      start = 1'($urandom);
      num   = 16'($urandom);
      resp  = 9'($urandom);
      @(posedge clk); #1;
    end
    chk("rst_busy", {31'd0, busy[0]}, 32'd0);
    chk("rst_done", {31'd0, done[0]}, 32'd0);
    chk("rst_sig",  {16'd0, sig[0]}, 32'h0000);
    chk("rst_cnt",  {16'd0, cnt[0]}, 32'd0);
    chk("rst_sig8", {16'd0, sig[2]}, 32'h8000);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      do_run(tbl[i].sel, tbl[i].n, 1'b0, tbl[i].cval, 1'b0, s, c);
      chk({tbl[i].nm, "_sig"}, {16'd0, s}, {16'd0, tbl[i].exp_sig});
      chk({tbl[i].nm, "_cnt"}, {16'd0, c}, {16'd0, tbl[i].exp_cnt});
    end

    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(2, 24);
      do_run(r % 3, n, 1'b1, 9'd0, r[0], s, c);
      chk("rand_sig", {16'd0, s}, {16'd0, model(seeds[r % 3], n)});
      chk("rand_cnt", {16'd0, c}, 32'(n));
    end

    do_run(0, 5, 1'b1, 9'd0, 1'b1, s, c);
    chk("ignore_sig", {16'd0, s}, {16'd0, model(16'h0000, 5)});
    do_run(0, 3, 1'b1, 9'd0, 1'b0, s, c);
    chk("restart_sig", {16'd0, s}, {16'd0, pkg_model(16'h0000, 3)});
    chk("restart_mdl", {16'd0, s}, {16'd0, model(16'h0000, 3)});
    chk("restart_cnt", {16'd0, c}, 32'd3);

    start = 1'b1;
    num   = 16'd40;
    resp  = 9'h155;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < ST + 4; i++) begin
      resp = 9'($urandom);
      @(posedge clk); #1;
    end
    chk("midrun_busy", {31'd0, busy[0]}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy[0]}, 32'd0);
    chk("arst_done", {31'd0, done[0]}, 32'd0);
    chk("arst_sig",  {16'd0, sig[0]}, 32'h0000);
    chk("arst_cnt",  {16'd0, cnt[0]}, 32'd0);
    chk("arst_sig1", {16'd0, sig[1]}, 32'h0001);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
